// File: rtl/array_w.sv
// -----------------------------------------------------------------------------
// array_w : write-side array controller
//
// Takes write frames from the frame splitter and turns each one into a
// bank access: open the row, wait tRCD, issue one column-write strobe per
// beat, wait for write recovery (tWR) and minimum row-active time (tRAS),
// close the bank, wait tRP, then pulse wr_end and return to idle.
//
// Frame word layout, MSB to LSB: {sof, eof, rw_flag, row, col, data}.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   frame_wr_valid/_data  incoming frame beat
//   frame_wr_ready        beat accepted when valid && ready
//   array_banksel_n       bank select, low while the row is open
//   array_raddr           row address (held until the next accepted sof)
//   array_cas_wr          column write strobe, one cycle per beat
//   array_caddr_wr        column address, valid while array_cas_wr is high
//   array_wdata           write data, valid while array_cas_wr is high
//   wr_end                one-cycle pulse, bank closed and ready for a frame
//   wr_err                (only with ARRAY_W_ERR_EN) pulse after a discarded
//                         idle beat
//   array_t*_cfg          timing in clock cycles, 0 behaves as 1
//
// Build option: define ARRAY_W_ERR_EN to add wr_err and to reject sof beats
// whose rw_flag is 0.
// -----------------------------------------------------------------------------
module array_w #(
  parameter int ARRAY_ROW_ADDR   = 14,
  parameter int ARRAY_COL_ADDR   = 6,
  parameter int ARRAY_DATA_WIDTH = 64,
  parameter int FRAME_DATA_WIDTH = 3 + ARRAY_ROW_ADDR + ARRAY_COL_ADDR + ARRAY_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_wr_valid,
  input  logic [FRAME_DATA_WIDTH-1:0] frame_wr_data,
  output logic                        frame_wr_ready,
  output logic                        array_banksel_n,
  output logic [ARRAY_ROW_ADDR-1:0]   array_raddr,
  output logic                        array_cas_wr,
  output logic [ARRAY_COL_ADDR-1:0]   array_caddr_wr,
  output logic [ARRAY_DATA_WIDTH-1:0] array_wdata,
  output logic                        wr_end,
`ifdef ARRAY_W_ERR_EN
  output logic                        wr_err,
`endif
  input  logic [7:0]                  array_trcd_cfg,
  input  logic [7:0]                  array_twr_cfg,
  input  logic [7:0]                  array_trp_cfg,
  input  logic [7:0]                  array_tras_cfg
);

  localparam int COL_LSB = ARRAY_DATA_WIDTH;
  localparam int ROW_LSB = COL_LSB + ARRAY_COL_ADDR;
  localparam int RW_BIT  = ROW_LSB + ARRAY_ROW_ADDR;
  localparam int EOF_BIT = RW_BIT + 1;
  localparam int SOF_BIT = RW_BIT + 2;

  typedef enum logic [2:0] {
    IDLE, WR_SRADDR, WR_RCD, WR_SEND, WR_LAST, WR_WR, WR_PRE_RP, WR_RP
  } state_t;

  state_t                      state_q, state_d;
  logic                        banksel_n_q, banksel_n_d;
  logic                        cas_wr_q, cas_wr_d;
  logic [ARRAY_ROW_ADDR-1:0]   raddr_q, raddr_d;
  logic [ARRAY_COL_ADDR-1:0]   caddr_q, caddr_d;
  logic [ARRAY_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ARRAY_COL_ADDR-1:0]   col_lat_q, col_lat_d;
  logic [ARRAY_DATA_WIDTH-1:0] data_lat_q, data_lat_d;
  logic                        eof_lat_q, eof_lat_d;
  logic [7:0]                  rcd_cnt_q, rcd_cnt_d;
  logic [7:0]                  twr_cnt_q, twr_cnt_d;
  logic [7:0]                  tras_cnt_q, tras_cnt_d;
  logic [7:0]                  rp_cnt_q, rp_cnt_d;
`ifdef ARRAY_W_ERR_EN
  logic                        wr_err_q, wr_err_d;
`endif

  // Frame fields
  logic                        f_sof, f_eof, start_ok, beat_fire, close_ok;
  logic [ARRAY_ROW_ADDR-1:0]   f_row;
  logic [ARRAY_COL_ADDR-1:0]   f_col;
  logic [ARRAY_DATA_WIDTH-1:0] f_data;

  assign f_sof  = frame_wr_data[SOF_BIT];
  assign f_eof  = frame_wr_data[EOF_BIT];
  assign f_row  = frame_wr_data[ROW_LSB +: ARRAY_ROW_ADDR];
  assign f_col  = frame_wr_data[COL_LSB +: ARRAY_COL_ADDR];
  assign f_data = frame_wr_data[ARRAY_DATA_WIDTH-1:0];

`ifdef ARRAY_W_ERR_EN
  assign start_ok = f_sof && frame_wr_data[RW_BIT];
`else
  // Without the error option the rw_flag bit carries no meaning here.
  logic unused_rw;
  assign unused_rw = frame_wr_data[RW_BIT];
  assign start_ok  = f_sof;
`endif

  function automatic logic [7:0] eff(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  // In WR_SEND a beat is taken only on a cycle without a strobe, which caps
  // the rate at one beat every two cycles.
  assign frame_wr_ready = (state_q == IDLE) || ((state_q == WR_SEND) && !cas_wr_q);
  assign beat_fire      = frame_wr_valid && frame_wr_ready;

  // Counters hold "cycles remaining including this one"; a value of 1 means
  // the interval expires at the end of the current cycle.
  assign close_ok = (twr_cnt_q <= 8'd1) && (tras_cnt_q <= 8'd1);

  always_comb begin
    state_d     = state_q;
    banksel_n_d = banksel_n_q;
    cas_wr_d    = 1'b0;
    raddr_d     = raddr_q;
    caddr_d     = caddr_q;
    wdata_d     = wdata_q;
    col_lat_d   = col_lat_q;
    data_lat_d  = data_lat_q;
    eof_lat_d   = eof_lat_q;
    rcd_cnt_d   = sat_dec(rcd_cnt_q);
    twr_cnt_d   = sat_dec(twr_cnt_q);
    tras_cnt_d  = sat_dec(tras_cnt_q);
    rp_cnt_d    = sat_dec(rp_cnt_q);
`ifdef ARRAY_W_ERR_EN
    wr_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (beat_fire) begin
          if (start_ok) begin
            raddr_d    = f_row;
            col_lat_d  = f_col;
            data_lat_d = f_data;
            eof_lat_d  = f_eof;
            state_d    = WR_SRADDR;
          end
`ifdef ARRAY_W_ERR_EN
          else begin
            wr_err_d = 1'b1;
          end
`endif
        end
      end
      WR_SRADDR: begin
        banksel_n_d = 1'b0;
        rcd_cnt_d   = eff(array_trcd_cfg);
        tras_cnt_d  = eff(array_tras_cfg);
        state_d     = WR_RCD;
      end
      WR_RCD: begin
        if (rcd_cnt_q <= 8'd1) begin
          cas_wr_d  = 1'b1;
          caddr_d   = col_lat_q;
          wdata_d   = data_lat_q;
          twr_cnt_d = eff(array_twr_cfg);
          state_d   = eof_lat_q ? WR_LAST : WR_SEND;
        end
      end
      WR_SEND: begin
        if (beat_fire) begin
          cas_wr_d  = 1'b1;
          caddr_d   = f_col;
          wdata_d   = f_data;
          twr_cnt_d = eff(array_twr_cfg);
          if (f_eof) state_d = WR_LAST;
        end
      end
      // The close is committed from the wait states themselves so that a
      // one-cycle tWR can still raise banksel_n right after the last strobe;
      // WR_PRE_RP is then the first cycle of the precharge interval.
      WR_LAST, WR_WR: begin
        if (close_ok) begin
          banksel_n_d = 1'b1;
          rp_cnt_d    = eff(array_trp_cfg);
          state_d     = WR_PRE_RP;
        end else begin
          state_d = WR_WR;
        end
      end
      WR_PRE_RP, WR_RP: begin
        state_d = (rp_cnt_q <= 8'd1) ? IDLE : WR_RP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      banksel_n_q <= 1'b1;
      cas_wr_q    <= 1'b0;
      raddr_q     <= '0;
      caddr_q     <= '0;
      wdata_q     <= '0;
      col_lat_q   <= '0;
      data_lat_q  <= '0;
      eof_lat_q   <= 1'b0;
      rcd_cnt_q   <= 8'd0;
      twr_cnt_q   <= 8'd0;
      tras_cnt_q  <= 8'd0;
      rp_cnt_q    <= 8'd0;
`ifdef ARRAY_W_ERR_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      banksel_n_q <= banksel_n_d;
      cas_wr_q    <= cas_wr_d;
      raddr_q     <= raddr_d;
      caddr_q     <= caddr_d;
      wdata_q     <= wdata_d;
      col_lat_q   <= col_lat_d;
      data_lat_q  <= data_lat_d;
      eof_lat_q   <= eof_lat_d;
      rcd_cnt_q   <= rcd_cnt_d;
      twr_cnt_q   <= twr_cnt_d;
      tras_cnt_q  <= tras_cnt_d;
      rp_cnt_q    <= rp_cnt_d;
`ifdef ARRAY_W_ERR_EN
      wr_err_q    <= wr_err_d;
`endif
    end
  end

  assign array_banksel_n = banksel_n_q;
  assign array_raddr     = raddr_q;
  assign array_cas_wr    = cas_wr_q;
  assign array_caddr_wr  = caddr_q;
  assign array_wdata     = wdata_q;
  // Last cycle of the precharge interval.
  assign wr_end = ((state_q == WR_PRE_RP) || (state_q == WR_RP)) && (rp_cnt_q <= 8'd1);
`ifdef ARRAY_W_ERR_EN
  assign wr_err = wr_err_q;
`endif

endmodule
